// File: rtl/luma_pool_8x8.sv
// rtl/luma_pool_8x8.sv - RGB rows to luma, 2x2 average pool, 4 words per 8x8 block on AXI-Stream (POOL_ROUND_EN: rounded pooling)
module luma_pool_8x8 #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] input_data1,
    input  logic [23:0] input_data2,
    input  logic [23:0] input_data3,
    input  logic [23:0] input_data4,
    input  logic [23:0] input_data5,
    input  logic [23:0] input_data6,
    input  logic [23:0] input_data7,
    input  logic [23:0] input_data8,
    input  logic        input_valid,
    output logic [31:0] m_axis_data,
    output logic        m_axis_valid,
    input  logic        m_axis_ready,
    output logic        m_axis_last,
    output logic        o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0][23:0] pix;
    logic [2:0]       row_cnt;
    logic [7:0][7:0]  y_reg;
    logic [7:0][7:0]  line_reg;
    logic             y_valid;
    logic [2:0]       y_row;
    logic [3:0][9:0]  pool_sum;
    logic [31:0]      pool_word;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             empty;
    logic             full;
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [32:0]      mem [FIFO_DEPTH];
    logic [32:0]      head;

    assign pix = {input_data8, input_data7, input_data6, input_data5,
                  input_data4, input_data3, input_data2, input_data1};

    function automatic logic [7:0] luma(input logic [23:0] p);
        logic [15:0] acc;
        acc = 16'd77 * {8'd0, p[23:16]} + 16'd150 * {8'd0, p[15:8]} + 16'd29 * {8'd0, p[7:0]};
        return 8'(acc >> 8);
    endfunction

    // Stage 1: luma per lane, tagged with the row index it belongs to
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_cnt <= '0;
            y_reg   <= '0;
            y_valid <= 1'b0;
            y_row   <= '0;
        end else begin
            y_valid <= input_valid;
            if (input_valid) begin
                row_cnt <= row_cnt + 3'd1;
                y_row   <= row_cnt;
                for (int k = 0; k < 8; k++) begin
                    y_reg[k] <= luma(pix[k]);
                end
            end
        end
    end

    always_comb begin
        pool_sum  = '0;
        pool_word = '0;
        for (int j = 0; j < 4; j++) begin
            pool_sum[j] = {2'b00, line_reg[2*j]} + {2'b00, line_reg[2*j+1]}
                        + {2'b00, y_reg[2*j]} + {2'b00, y_reg[2*j+1]};
`ifdef POOL_ROUND_EN
            pool_word[8*j +: 8] = 8'((pool_sum[j] + 10'd2) >> 2);
`else
            pool_word[8*j +: 8] = 8'(pool_sum[j] >> 2);
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_reg <= '0;
        end else if (y_valid && !y_row[0]) begin
            line_reg <= y_reg;
        end
    end

    assign push  = y_valid & y_row[0];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign pop   = m_axis_valid & m_axis_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign wr_en = push & (~full | pop);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {(y_row == 3'd7), pool_word};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign head         = empty ? 33'd0 : mem[rd_ptr[AW-1:0]];
    assign m_axis_valid = ~empty;
    assign m_axis_data  = head[31:0];
    assign m_axis_last  = head[32];

endmodule

// File: tb/tb_luma_pool_8x8.sv
// tb/tb_luma_pool_8x8.sv - scoreboard bench for luma_pool_8x8
module tb_luma_pool_8x8;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [7:0][23:0] pix;
    logic             input_valid;
    logic [31:0]      m_axis_data;
    logic             m_axis_valid;
    logic             m_axis_ready;
    logic             m_axis_last;
    logic             o_overflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] sb [$];
    bit          sb_en    = 1'b1;
    int          mrow     = 0;
    logic [7:0]  mline [8];

    always #5 i_clk = ~i_clk;

    luma_pool_8x8 #(.FIFO_DEPTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .input_data1  (pix[0]),
        .input_data2  (pix[1]),
        .input_data3  (pix[2]),
        .input_data4  (pix[3]),
        .input_data5  (pix[4]),
        .input_data6  (pix[5]),
        .input_data7  (pix[6]),
        .input_data8  (pix[7]),
        .input_valid  (input_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .o_overflow   (o_overflow)
    );

    function automatic logic [7:0] model_luma(input logic [23:0] p);
        int acc;
        acc = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
        return 8'(acc / 256);
    endfunction

    function automatic logic [7:0] model_pool(input int a, input int b, input int c, input int d);
        int s;
        s = a + b + c + d;
`ifdef POOL_ROUND_EN
        s = s + 2;
`endif
        return 8'(s / 4);
    endfunction

    task automatic send_row(input logic [7:0][23:0] p);
        logic [7:0]  y [8];
        logic [31:0] w;
        @(posedge i_clk); #1;
        pix         = p;
        input_valid = 1'b1;
        for (int k = 0; k < 8; k++) y[k] = model_luma(p[k]);
        if (mrow % 2 == 0) begin
            for (int k = 0; k < 8; k++) mline[k] = y[k];
        end else begin
            for (int j = 0; j < 4; j++)
                w[8*j +: 8] = model_pool(int'(mline[2*j]), int'(mline[2*j+1]), int'(y[2*j]), int'(y[2*j+1]));
            if (sb_en) sb.push_back({(mrow == 7), w});
        end
        mrow = (mrow + 1) % 8;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            input_valid = 1'b0;
        end
    endtask

    task automatic send_block_const(input logic [23:0] v);
        for (int r = 0; r < 8; r++) send_row({8{v}});
    endtask

    task automatic send_block_rand();
        logic [7:0][23:0] p;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) p[k] = 24'($urandom);
            send_row(p);
        end
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst       = 1'b1;
        input_valid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        mrow  = 0;
    endtask

    task automatic wait_drain(output int left);
        int cyc;
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge i_clk);
            cyc++;
        end
        repeat (4) @(posedge i_clk);
        #1;
        left = sb.size();
    endtask

    always @(negedge i_clk) begin : monitor
        logic [32:0] e;
        if (!i_rst && m_axis_valid && m_axis_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL stream_unexpected: got last=%b data=%h, required no word", m_axis_last, m_axis_data);
            end else begin
                e = sb.pop_front();
                if ({m_axis_last, m_axis_data} !== e) begin
                    n_fail++;
                    $display("FAIL stream_word: got last=%b data=%h, required last=%b data=%h",
                             m_axis_last, m_axis_data, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        int left;
        i_rst        = 1'b1;
        m_axis_ready = 1'b1;
        pix          = {8{24'hFFFFFF}};
        input_valid  = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_checks += 4;
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", m_axis_valid); end
        if (m_axis_data !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %h, required 0", m_axis_data); end
        if (m_axis_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b, required 0", m_axis_last); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b, required 0", o_overflow); end
        @(posedge i_clk); #1;
        input_valid = 1'b0;
        i_rst       = 1'b0;
        mrow        = 0;
        send_row({8{24'h123456}});
        idle(1);
        do_reset();
        n_checks++;
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", m_axis_valid); end
        send_block_const(24'h808080);
        idle(2);
        wait_drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL rst_realign_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_latency_white();
        int left;
        m_axis_ready = 1'b1;
        send_row({8{24'hFFFFFF}});
        send_row({8{24'hFFFFFF}});
        @(negedge i_clk);
        n_checks++;
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle0: got valid=%b, required 0", m_axis_valid); end
        @(posedge i_clk); #1;
        input_valid = 1'b0;
        @(negedge i_clk);
        n_checks++;
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1: got valid=%b, required 0", m_axis_valid); end
        @(negedge i_clk);
        n_checks += 2;
        if (m_axis_valid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2: got valid=%b, required 1", m_axis_valid); end
        if (m_axis_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL white_word0: got %h, required ffffffff", m_axis_data); end
        for (int r = 2; r < 8; r++) send_row({8{24'hFFFFFF}});
        idle(1);
        wait_drain(left);
        n_checks += 2;
        if (left !== 0) begin n_fail++; $display("FAIL white_drain: got %0d pending, required 0", left); end
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL white_idle_valid: got %b, required 0", m_axis_valid); end
    endtask

    task automatic test_colors();
        int left;
        m_axis_ready = 1'b1;
        send_block_const(24'hFF0000);
        send_block_const(24'h00FF00);
        send_block_const(24'h0000FF);
        send_block_rand();
        send_block_rand();
        idle(1);
        wait_drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL colors_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_rounding();
        logic [7:0][23:0] p;
        logic [7:0]       exp_b0;
        int               cyc;
        int               left;
`ifdef POOL_ROUND_EN
        exp_b0 = 8'h02;
`else
        exp_b0 = 8'h01;
`endif
        m_axis_ready = 1'b1;
        p    = '0;
        p[0] = 24'h010101;
        p[1] = 24'h020202;
        send_row(p);
        p[0] = 24'h020202;
        send_row(p);
        idle(1);
        cyc = 0;
        @(negedge i_clk);
        while (m_axis_valid !== 1'b1 && cyc < 20) begin
            @(negedge i_clk);
            cyc++;
        end
        n_checks++;
        if (m_axis_valid !== 1'b1 || m_axis_data[7:0] !== exp_b0) begin
            n_fail++;
            $display("FAIL round_byte0: got valid=%b byte0=%h, required valid=1 byte0=%h", m_axis_valid, m_axis_data[7:0], exp_b0);
        end
        for (int r = 2; r < 8; r++) send_row('0);
        idle(1);
        wait_drain(left);
        n_checks++;
        if (left !== 0) begin n_fail++; $display("FAIL round_drain: got %0d pending, required 0", left); end
    endtask

    task automatic test_backpressure();
        logic [31:0] head;
        int          left;
        do_reset();
        m_axis_ready = 1'b0;
        sb_en        = 1'b1;
        send_block_rand();
        idle(3);
        head = sb[0][31:0];
        n_checks += 3;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_full_no_ovf: got %b, required 0", o_overflow); end
        if (m_axis_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b, required 1", m_axis_valid); end
        if (m_axis_data !== head) begin n_fail++; $display("FAIL bp_head: got %h, required %h", m_axis_data, head); end
        sb_en = 1'b0;
        send_block_rand();
        send_block_rand();
        idle(3);
        sb_en = 1'b1;
        n_checks++;
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b, required 1", o_overflow); end
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            n_checks++;
            if (m_axis_data !== head || m_axis_last !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got data=%h last=%b, required data=%h last=0", m_axis_data, m_axis_last, head);
            end
        end
        @(posedge i_clk); #1;
        m_axis_ready = 1'b1;
        wait_drain(left);
        n_checks += 3;
        if (left !== 0) begin n_fail++; $display("FAIL bp_drain: got %0d pending, required 0", left); end
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid=%b, required 0", m_axis_valid); end
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b, required 1", o_overflow); end
    endtask

    task automatic test_full_pop();
        logic [7:0][23:0] p;
        int               left;
        do_reset();
        n_checks++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf_cleared: got %b, required 0", o_overflow); end
        m_axis_ready = 1'b0;
        send_block_rand();
        idle(3);
        for (int k = 0; k < 8; k++) p[k] = 24'($urandom);
        send_row(p);
        for (int k = 0; k < 8; k++) p[k] = 24'($urandom);
        send_row(p);
        @(posedge i_clk); #1;
        input_valid  = 1'b0;
        m_axis_ready = 1'b1;
        @(posedge i_clk); #1;
        m_axis_ready = 1'b0;
        idle(2);
        n_checks++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fp_no_overflow: got %b, required 0", o_overflow); end
        m_axis_ready = 1'b1;
        for (int r = 2; r < 8; r++) begin
            for (int k = 0; k < 8; k++) p[k] = 24'($urandom);
            send_row(p);
        end
        idle(1);
        wait_drain(left);
        n_checks += 3;
        if (left !== 0) begin n_fail++; $display("FAIL fp_count: got %0d pending, required 0", left); end
        if (m_axis_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty: got valid=%b, required 0", m_axis_valid); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fp_ovf_end: got %b, required 0", o_overflow); end
    endtask

    initial begin
        i_rst        = 1'b1;
        input_valid  = 1'b0;
        pix          = '0;
        m_axis_ready = 1'b0;
        test_reset();
        test_latency_white();
        test_colors();
        test_rounding();
        test_backpressure();
        test_full_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
